// File: rtl/dac_wavegen.sv
// Phase-accumulator waveform source (saw/triangle/square/DC) with an AXI-Stream master output.
// Define WAVEGEN_AMPLITUDE_EN to add a latched gain input and a registered scaling stage.
module dac_wavegen #(
  parameter int PHASE_W  = 32,
  parameter int SAMPLE_W = 16
) (
  input  logic                mclk,
  input  logic                rst,
  input  logic                en,
  input  logic                cfg_load,
  input  logic                cfg_phase_clr,
  input  logic [PHASE_W-1:0]  phase_step,
  input  logic [1:0]          wave_sel,
  input  logic [SAMPLE_W-1:0] dc_level,
`ifdef WAVEGEN_AMPLITUDE_EN
  input  logic [7:0]          gain,
`endif
  output logic                m_axis_valid,
  input  logic                m_axis_ready,
  output logic [SAMPLE_W-1:0] m_axis_data,
  output logic [31:0]         sample_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_MUL, S_VALID} state_t;

`ifdef WAVEGEN_AMPLITUDE_EN
  localparam state_t S_LAST_CALC = S_MUL;
`else
  localparam state_t S_LAST_CALC = S_CALC;
`endif

  state_t              r_state, w_state_nxt;
  logic [PHASE_W-1:0]  r_phase, r_step;
  logic [1:0]          r_wave;
  logic [SAMPLE_W-1:0] r_dc, r_data, w_p, w_raw, w_sample;
  logic [31:0]         r_cnt;
  logic                w_hs, w_data_ld;

  // state register
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (en) w_state_nxt = S_CALC;
`ifdef WAVEGEN_AMPLITUDE_EN
      S_CALC:  w_state_nxt = S_MUL;
`else
      S_CALC:  w_state_nxt = S_VALID;
`endif
      S_MUL:   w_state_nxt = S_VALID;
      S_VALID: if (m_axis_ready) w_state_nxt = en ? S_CALC : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // outputs / strobes
  always_comb begin
    m_axis_valid = 1'b0;
    w_hs         = 1'b0;
    w_data_ld    = (r_state == S_LAST_CALC);
    if (r_state == S_VALID) begin
      m_axis_valid = 1'b1;
      w_hs         = m_axis_ready;
    end
  end

  assign w_p = r_phase[PHASE_W-1 -: SAMPLE_W];

  always_comb begin
    w_raw = '0;
    case (r_wave)
      2'd0:    w_raw = w_p;
      2'd1:    w_raw = w_p[SAMPLE_W-1] ? ~{w_p[SAMPLE_W-2:0], 1'b0} : {w_p[SAMPLE_W-2:0], 1'b0};
      2'd2:    w_raw = {SAMPLE_W{w_p[SAMPLE_W-1]}};
      default: w_raw = r_dc;
    endcase
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_step <= '0;
      r_wave <= '0;
      r_dc   <= '0;
    end else if (cfg_load) begin
      r_step <= phase_step;
      r_wave <= wave_sel;
      r_dc   <= dc_level;
    end
  end

  // a phase clear wins over the increment of a coincident handshake
  always_ff @(posedge mclk or posedge rst) begin
    if (rst)                          r_phase <= '0;
    else if (cfg_load && cfg_phase_clr) r_phase <= '0;
    else if (w_hs)                    r_phase <= r_phase + r_step;
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst)       r_cnt <= '0;
    else if (w_hs) r_cnt <= r_cnt + 32'd1;
  end

`ifdef WAVEGEN_AMPLITUDE_EN
  logic [7:0]          r_gain;
  logic [8:0]          w_gain_p1;
  logic [SAMPLE_W+8:0] w_prod;
  logic [SAMPLE_W-1:0] r_scaled;

  assign w_gain_p1 = {1'b0, r_gain} + 9'd1;
  assign w_prod    = {9'd0, w_raw} * {{SAMPLE_W{1'b0}}, w_gain_p1};

  always_ff @(posedge mclk or posedge rst) begin
    if (rst)           r_gain <= 8'hFF;
    else if (cfg_load) r_gain <= gain;
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst)                    r_scaled <= '0;
    else if (r_state == S_CALC) r_scaled <= SAMPLE_W'(w_prod >> 8);
  end

  assign w_sample = r_scaled;
`else
  assign w_sample = w_raw;
`endif

  // data only changes while computing, so a presented sample stays put
  always_ff @(posedge mclk or posedge rst) begin
    if (rst)            r_data <= '0;
    else if (w_data_ld) r_data <= w_sample;
  end

  assign m_axis_data = r_data;
  assign sample_cnt  = r_cnt;

endmodule

// File: tb/tb_dac_wavegen.sv
// Self-checking bench for dac_wavegen: directed scenarios plus randomized runs against a phase/config model.
module tb_dac_wavegen;
  logic        mclk = 1'b0;
  logic        rst, en, cfg_load, cfg_phase_clr, m_axis_ready;
  logic [31:0] phase_step;
  logic [1:0]  wave_sel;
  logic [15:0] dc_level;
  logic        m_axis_valid;
  logic [15:0] m_axis_data;
  logic [31:0] sample_cnt;
`ifdef WAVEGEN_AMPLITUDE_EN
  logic [7:0]  gain;
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] m_phase, m_step, m_cnt;
  logic [1:0]  m_wave;
  logic [15:0] m_dc;
  int          m_gain;

  dac_wavegen dut (
    .mclk(mclk), .rst(rst), .en(en), .cfg_load(cfg_load), .cfg_phase_clr(cfg_phase_clr),
    .phase_step(phase_step), .wave_sel(wave_sel), .dc_level(dc_level),
`ifdef WAVEGEN_AMPLITUDE_EN
    .gain(gain),
`endif
    .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
    .m_axis_data(m_axis_data), .sample_cnt(sample_cnt)
  );

  always #5 mclk = ~mclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] exp_sample(input logic [31:0] ph);
    int p, r;
    p = int'(ph / 32'd65536);
    case (m_wave)
      2'd0:    r = p;
      2'd1:    r = (p >= 32768) ? 65535 - ((2 * p) % 65536) : (2 * p) % 65536;
      2'd2:    r = (p >= 32768) ? 65535 : 0;
      default: r = int'(m_dc);
    endcase
    r = (r * (m_gain + 1)) / 256;
    return 16'(r);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_step = 0; m_cnt = 0; m_wave = 0; m_dc = 0; m_gain = 255;
  endtask

  // commit current inputs through one rising edge, mirroring them into the model
  task automatic cyc();
    if (m_axis_valid && m_axis_ready) begin
      m_phase = m_phase + m_step;
      m_cnt   = m_cnt + 1;
    end
    if (cfg_load) begin
      m_step = phase_step; m_wave = wave_sel; m_dc = dc_level;
`ifdef WAVEGEN_AMPLITUDE_EN
      m_gain = int'(gain);
`endif
      if (cfg_phase_clr) m_phase = 0;
    end
    @(negedge mclk);
    cfg_load = 1'b0;
    cfg_phase_clr = 1'b0;
  endtask

  task automatic load(input logic [31:0] st, input logic [1:0] w, input logic [15:0] dc, input logic clr);
    phase_step = st; wave_sel = w; dc_level = dc; cfg_load = 1'b1; cfg_phase_clr = clr;
    cyc();
  endtask

  task automatic go_idle();
    en = 1'b0; m_axis_ready = 1'b1;
    repeat (6) cyc();
    m_axis_ready = 1'b0;
  endtask

  task automatic wait_valid();
    for (int w = 0; w < 8 && !m_axis_valid; w++) cyc();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge mclk);
    total++; if (m_axis_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", m_axis_valid); end
    total++; if (m_axis_data !== 16'h0) begin bad++; $display("FAIL rst_data: got %h want 0000", m_axis_data); end
    total++; if (sample_cnt !== 32'h0) begin bad++; $display("FAIL rst_cnt: got %h want 0", sample_cnt); end
    rst = 1'b0;
    repeat (3) cyc();
    total++; if (m_axis_valid !== 1'b0) begin bad++; $display("FAIL idle_no_en: got %b want 0", m_axis_valid); end
  endtask

  task automatic test_saw();
    logic [31:0] c0;
    load(32'h0100_0000, 2'd0, 16'h0, 1'b1);
    m_axis_ready = 1'b1; en = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      cyc();
      total++;
      if (m_axis_valid !== (i == LAT)) begin bad++; $display("FAIL latency[%0d]: got %b want %b", i, m_axis_valid, i == LAT); end
    end
    c0 = m_cnt;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (m_axis_data !== 16'(k * 256)) begin bad++; $display("FAIL saw[%0d]: got %h want %h", k, m_axis_data, 16'(k * 256)); end
      cyc();
      wait_valid();
    end
    total++; if (sample_cnt !== c0 + 8) begin bad++; $display("FAIL saw_cnt: got %0d want %0d", sample_cnt, c0 + 8); end
    go_idle();
  endtask

  task automatic test_tri_square();
    logic [15:0] tri_t [4];
    logic [15:0] sq_t  [4];
    logic [15:0] want;
    tri_t = '{16'h0000, 16'h8000, 16'hFFFF, 16'h7FFF};
    sq_t  = '{16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
    for (int pass = 0; pass < 2; pass++) begin
      load(32'h4000_0000, (pass == 0) ? 2'd1 : 2'd2, 16'h0, 1'b1);
      m_axis_ready = 1'b1; en = 1'b1;
      cyc();
      wait_valid();
      for (int k = 0; k < 8; k++) begin
        want = (pass == 0) ? tri_t[k % 4] : sq_t[k % 4];
        total++;
        if (m_axis_data !== want) begin bad++; $display("FAIL %s[%0d]: got %h want %h", (pass == 0) ? "tri" : "square", k, m_axis_data, want); end
        cyc();
        wait_valid();
      end
      go_idle();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] d0;
    logic [31:0] c0;
    load($urandom, 2'd0, 16'h0, 1'b0);
    m_axis_ready = 1'b0; en = 1'b1;
    cyc();
    wait_valid();
    d0 = m_axis_data;
    c0 = m_cnt;
    total++; if (d0 !== exp_sample(m_phase)) begin bad++; $display("FAIL bp_first: got %h want %h", d0, exp_sample(m_phase)); end
    for (int i = 0; i < 50; i++) begin
      cyc();
      total++;
      if (m_axis_valid !== 1'b1 || m_axis_data !== d0 || sample_cnt !== c0) begin
        bad++; $display("FAIL bp_hold[%0d]: got v=%b d=%h c=%0d want v=1 d=%h c=%0d", i, m_axis_valid, m_axis_data, sample_cnt, d0, c0);
      end
    end
    for (int p = 0; p < 3; p++) begin
      m_axis_ready = 1'b1;
      cyc();
      m_axis_ready = 1'b0;
      repeat (99) cyc();
      total++;
      if (sample_cnt !== c0 + 32'(p + 1) || m_axis_valid !== 1'b1 || m_axis_data !== exp_sample(m_phase)) begin
        bad++; $display("FAIL bp_pulse[%0d]: got c=%0d d=%h want c=%0d d=%h", p, sample_cnt, m_axis_data, c0 + 32'(p + 1), exp_sample(m_phase));
      end
    end
    go_idle();
  endtask

  task automatic test_cfg_midflight();
    logic [15:0] d0;
    load(32'h0123_4567, 2'd0, 16'h0, 1'b1);
    m_axis_ready = 1'b1; en = 1'b1;
    repeat (7) cyc();
    m_axis_ready = 1'b0;
    wait_valid();
    d0 = m_axis_data;
    total++; if (d0 !== exp_sample(m_phase)) begin bad++; $display("FAIL mid_pend: got %h want %h", d0, exp_sample(m_phase)); end
    load(32'h0123_4567, 2'd3, 16'h1234, 1'b1);
    total++;
    if (m_axis_valid !== 1'b1 || m_axis_data !== d0) begin bad++; $display("FAIL mid_keep: got v=%b d=%h want v=1 d=%h", m_axis_valid, m_axis_data, d0); end
    m_axis_ready = 1'b1;
    cyc();
    m_axis_ready = 1'b0;
    wait_valid();
    total++; if (m_axis_data !== 16'h1234) begin bad++; $display("FAIL mid_dc: got %h want 1234", m_axis_data); end
    // clear coinciding with a handshake
    m_axis_ready = 1'b1;
    load(32'h0123_4567, 2'd0, 16'h0, 1'b1);
    m_axis_ready = 1'b0;
    wait_valid();
    total++; if (m_axis_data !== 16'h0000) begin bad++; $display("FAIL clr_hs_data: got %h want 0000", m_axis_data); end
    total++; if (sample_cnt !== m_cnt) begin bad++; $display("FAIL clr_hs_cnt: got %0d want %0d", sample_cnt, m_cnt); end
    m_axis_ready = 1'b1;
    cyc();
    m_axis_ready = 1'b0;
    wait_valid();
    total++; if (m_axis_data !== 16'h0123) begin bad++; $display("FAIL clr_hs_next: got %h want 0123", m_axis_data); end
    go_idle();
  endtask

  task automatic test_en_drop();
    logic [15:0] d0;
    load($urandom, 2'd0, 16'h0, 1'b0);
    m_axis_ready = 1'b0; en = 1'b1;
    cyc();
    wait_valid();
    d0 = m_axis_data;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      total++;
      if (m_axis_valid !== 1'b1 || m_axis_data !== d0) begin bad++; $display("FAIL endrop_hold[%0d]: got v=%b d=%h want v=1 d=%h", i, m_axis_valid, m_axis_data, d0); end
    end
    m_axis_ready = 1'b1;
    cyc();
    m_axis_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (m_axis_valid !== 1'b0 || sample_cnt !== m_cnt) begin bad++; $display("FAIL endrop_idle[%0d]: got v=%b c=%0d want v=0 c=%0d", i, m_axis_valid, sample_cnt, m_cnt); end
      cyc();
    end
    en = 1'b1;
    cyc();
    wait_valid();
    total++; if (m_axis_data !== exp_sample(m_phase)) begin bad++; $display("FAIL endrop_phase: got %h want %h", m_axis_data, exp_sample(m_phase)); end
    go_idle();
  endtask

  task automatic test_step_zero();
    logic [15:0] d0;
    load(32'h0, 2'd1, 16'h0, 1'b0);
    m_axis_ready = 1'b1; en = 1'b1;
    cyc();
    wait_valid();
    d0 = exp_sample(m_phase);
    for (int k = 0; k < 5; k++) begin
      total++;
      if (m_axis_data !== d0) begin bad++; $display("FAIL step0[%0d]: got %h want %h", k, m_axis_data, d0); end
      cyc();
      wait_valid();
    end
    go_idle();
  endtask

`ifdef WAVEGEN_AMPLITUDE_EN
  task automatic test_gain();
    gain = 8'h7F;
    load(32'h8000_0000, 2'd0, 16'h0, 1'b1);
    m_axis_ready = 1'b1; en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      total++;
      if (m_axis_valid !== (i == 3)) begin bad++; $display("FAIL gain_lat[%0d]: got %b want %b", i, m_axis_valid, i == 3); end
    end
    total++; if (m_axis_data !== 16'h0000) begin bad++; $display("FAIL gain_s0: got %h want 0000", m_axis_data); end
    cyc();
    wait_valid();
    total++; if (m_axis_data !== 16'h4000) begin bad++; $display("FAIL gain_half: got %h want 4000", m_axis_data); end
    go_idle();
    gain = 8'hFF;
  endtask
`endif

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      go_idle();
`ifdef WAVEGEN_AMPLITUDE_EN
      gain = 8'($urandom_range(0, 255));
`endif
      load(($urandom_range(0, 3) == 0) ? 32'h0 : $urandom, 2'($urandom_range(0, 3)),
           16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 60; i++) begin
        en = ($urandom_range(0, 9) != 0);
        m_axis_ready = 1'($urandom_range(0, 1));
        if (m_axis_valid) begin
          total++;
          if (m_axis_data !== exp_sample(m_phase)) begin bad++; $display("FAIL rand_data[%0d.%0d]: got %h want %h", r, i, m_axis_data, exp_sample(m_phase)); end
        end
        total++;
        if (sample_cnt !== m_cnt) begin bad++; $display("FAIL rand_cnt[%0d.%0d]: got %0d want %0d", r, i, sample_cnt, m_cnt); end
        cyc();
      end
    end
    go_idle();
`ifdef WAVEGEN_AMPLITUDE_EN
    gain = 8'hFF;
`endif
  endtask

  task automatic test_async_reset();
    load(32'h0100_0000, 2'd0, 16'h0, 1'b1);
    m_axis_ready = 1'b1; en = 1'b1;
    repeat (5) cyc();
    m_axis_ready = 1'b0;
    wait_valid();
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++; if (m_axis_valid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %b want 0", m_axis_valid); end
    total++; if (m_axis_data !== 16'h0) begin bad++; $display("FAIL arst_data: got %h want 0000", m_axis_data); end
    total++; if (sample_cnt !== 32'h0) begin bad++; $display("FAIL arst_cnt: got %h want 0", sample_cnt); end
    @(negedge mclk);
    rst = 1'b0;
    model_reset();
    m_axis_ready = 1'b1; en = 1'b1;
    cyc();
    wait_valid();
    total++;
    if (m_axis_valid !== 1'b1 || m_axis_data !== 16'h0) begin bad++; $display("FAIL arst_restart: got v=%b d=%h want v=1 d=0000", m_axis_valid, m_axis_data); end
    go_idle();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_load = 1'b0; cfg_phase_clr = 1'b0; m_axis_ready = 1'b0;
    phase_step = '0; wave_sel = '0; dc_level = '0;
`ifdef WAVEGEN_AMPLITUDE_EN
    gain = 8'hFF;
`endif
    model_reset();
    test_reset();
    test_saw();
    test_tri_square();
    test_backpressure();
    test_cfg_midflight();
    test_en_drop();
    test_step_zero();
`ifdef WAVEGEN_AMPLITUDE_EN
    test_gain();
`endif
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
